// File: rtl/pbit_sweep_scheduler_pkg.sv
// pbit_pkg: shared fixed-point constants, sign-magnitude <-> two's-complement
// conversion helpers and the sweep FSM state encoding.
//   N             word width (1 sign bit + N-1 magnitude bits)
//   Q             fractional bits
//   ONE_SM        +1.0 in sign-magnitude
//   CLAMP_MAX_SM  largest representable field after clamping (+7.75 at defaults)
//   CLAMP_MIN_SM  smallest field after clamping (-8.0 at defaults)
package pbit_pkg;

    localparam int N = 7;
    localparam int Q = 2;

    // Clamp limits expressed in units of 2^-Q.
    localparam int CLAMP_MAX_TC = (2 ** (N - 2)) - 1;
    localparam int CLAMP_MIN_TC = -(2 ** (N - 2));

    localparam logic [N-1:0] ONE_SM       = N'(2 ** Q);
    localparam logic [N-1:0] CLAMP_MAX_SM = N'(CLAMP_MAX_TC);
    localparam logic [N-1:0] CLAMP_MIN_SM = {1'b1, (N-1)'(2 ** (N - 2))};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CLAMP = 3'd3,
        ST_FIRE  = 3'd4
    } state_t;

    // Negative zero maps to 0 because negating a zero magnitude yields 0.
    function automatic logic signed [N-1:0] sm2tc(input logic [N-1:0] sm);
        logic signed [N-1:0] mag;
        mag = signed'({1'b0, sm[N-2:0]});
        return sm[N-1] ? -mag : mag;
    endfunction

    // Zero always comes out as +0.
    function automatic logic [N-1:0] tc2sm(input logic signed [N-1:0] tc);
        logic [N-2:0] mag;
        mag = tc[N-1] ? (N-1)'(-tc) : (N-1)'(tc);
        return {tc[N-1], mag};
    endfunction

endpackage

// File: rtl/pbit_field_accum.sv
// pbit_field_accum: serial local-field accumulator shared by all p-bits.
// Each added word is converted from sign-magnitude, optionally negated, and
// summed into a register wide enough that it can never overflow. z_sm is the
// combinational clamped, sign-magnitude view of the running sum.
//   CLK, RST  clock, asynchronous active-high reset
//   clr       zero the accumulator (wins over add_en)
//   add_en    add the current data word
//   neg       negate the current word before adding
//   data      sign-magnitude word from the table
//   z_sm      clamped sum, sign-magnitude
module pbit_field_accum
    import pbit_pkg::*;
#(
    parameter int ACC_W = N + 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         add_en,
    input  logic         neg,
    input  logic [N-1:0] data,
    output logic [N-1:0] z_sm
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(CLAMP_MAX_TC);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(CLAMP_MIN_TC);

    logic signed [N-1:0]     w_tc;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] r_acc;

    assign w_tc   = sm2tc(data);
    assign w_ext  = ACC_W'(w_tc);
    assign w_term = neg ? -w_ext : w_ext;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (add_en) begin
            r_acc <= r_acc + w_term;
        end
    end

    // Within the clamp range the low N bits already hold the exact value.
    always_comb begin
        z_sm = tc2sm(N'(r_acc));
        if (r_acc > ACC_MAX) begin
            z_sm = CLAMP_MAX_SM;
        end else if (r_acc < ACC_MIN) begin
            z_sm = CLAMP_MIN_SM;
        end
    end

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// pbit_sweep_scheduler: Gibbs-sweep controller. For each p-bit in turn it
// reads the bias and the off-diagonal weights from an external table,
// accumulates the local field, clamps it onto z and pulses that p-bit's
// enable. Runs num_sweeps sweeps (0 = until stop).
//   CLK, RST     clock, asynchronous active-high reset
//   start        begin a run (ignored while busy)
//   stop         finish the current p-bit update, then go idle
//   num_sweeps   sweeps per run, sampled on start
//   m            current p-bit outputs (1 = +1, 0 = -1)
//   tbl_rd       table read strobe
//   tbl_addr     table address (w_ij at i*NUM_PBITS+j, b_i after the matrix)
//   tbl_data     table read data
//   z            clamped local field, held until the next clamp
//   pbit_en      one-hot enable of the p-bit being updated
//   busy         run in progress
//   sweep_done   one-cycle pulse at the end of each full sweep
//   sweep_count  completed sweeps in the current run
//   dbg_state    current FSM state
//
// Table interface: fixed-latency read, no back-pressure. tbl_data belongs to
// the address presented with tbl_rd on the previous cycle, every time.
module pbit_sweep_scheduler
    import pbit_pkg::*;
#(
    parameter int NUM_PBITS = 3,
    parameter int EN_CYCLES = 2,
    parameter int AW        = $clog2(NUM_PBITS * NUM_PBITS + NUM_PBITS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          num_sweeps,
    input  logic [NUM_PBITS-1:0] m,
    output logic                 tbl_rd,
    output logic [AW-1:0]        tbl_addr,
    input  logic [N-1:0]         tbl_data,
    output logic [N-1:0]         z,
    output logic [NUM_PBITS-1:0] pbit_en,
    output logic                 busy,
    output logic                 sweep_done,
    output logic [15:0]          sweep_count,
    output logic [2:0]           dbg_state
);

    localparam int IW    = $clog2(NUM_PBITS);
    localparam int CMAX  = (NUM_PBITS > EN_CYCLES) ? NUM_PBITS : EN_CYCLES;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int ACC_W = N + $clog2(NUM_PBITS) + 1;

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_i, w_i_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [15:0]    r_sweep_count, w_sweep_count_nxt;
    logic [15:0]    r_num_sweeps;
    logic           r_stop_pend;
    logic           w_stop_eff;
    logic           w_sweep_done;
    logic [IW-1:0]  w_j;
    logic           r_rd_d;
    logic [IW-1:0]  r_prev_j;
    logic           r_prev_bias;
    logic [N-1:0]   r_z;
    logic [N-1:0]   w_z_sm;

    // Fetch slot k>0 reads column k-1, skipping the diagonal.
    always_comb begin
        int k;
        k   = int'(r_cnt) - 1;
        w_j = (k < int'(r_i)) ? IW'(k) : IW'(k + 1);
    end

    assign w_stop_eff = r_stop_pend | stop;

    always_comb begin
        w_state_nxt       = r_state;
        w_i_nxt           = r_i;
        w_cnt_nxt         = r_cnt;
        w_sweep_count_nxt = r_sweep_count;
        w_sweep_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt       = ST_FETCH;
                    w_i_nxt           = '0;
                    w_cnt_nxt         = '0;
                    w_sweep_count_nxt = '0;
                end
            end
            ST_FETCH: begin
                if (r_cnt == CW'(NUM_PBITS - 1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DRAIN: w_state_nxt = ST_CLAMP;
            ST_CLAMP: begin
                w_state_nxt = ST_FIRE;
                w_cnt_nxt   = '0;
            end
            ST_FIRE: begin
                if (r_cnt == CW'(EN_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_i != IW'(NUM_PBITS - 1)) begin
                        w_i_nxt     = r_i + IW'(1);
                        w_state_nxt = w_stop_eff ? ST_IDLE : ST_FETCH;
                    end else begin
                        w_sweep_done      = 1'b1;
                        w_sweep_count_nxt = r_sweep_count + 16'd1;
                        w_i_nxt           = '0;
                        if (((r_num_sweeps != 16'd0) && (w_sweep_count_nxt == r_num_sweeps))
                            || w_stop_eff) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_i           <= '0;
            r_cnt         <= '0;
            r_sweep_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_i           <= w_i_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sweep_count <= w_sweep_count_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_num_sweeps <= '0;
            r_stop_pend  <= 1'b0;
            r_rd_d       <= 1'b0;
            r_prev_j     <= '0;
            r_prev_bias  <= 1'b0;
            r_z          <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_num_sweeps <= num_sweeps;
            end
            // A stop seen together with start in IDLE is kept for the run.
            if (w_state_nxt == ST_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end
            r_rd_d      <= tbl_rd;
            r_prev_j    <= w_j;
            r_prev_bias <= (r_cnt == '0);
            if (r_state == ST_CLAMP) begin
                r_z <= w_z_sm;
            end
        end
    end

    pbit_field_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .CLK    (CLK),
        .RST    (RST),
        .clr    ((r_state == ST_FETCH) && (r_cnt == '0)),
        .add_en (r_rd_d),
        .neg    (!r_prev_bias && !m[r_prev_j]),
        .data   (tbl_data),
        .z_sm   (w_z_sm)
    );

    assign tbl_rd      = (r_state == ST_FETCH);
    assign tbl_addr    = !tbl_rd ? '0 :
                         (r_cnt == '0) ? AW'(NUM_PBITS * NUM_PBITS) + AW'(r_i)
                                       : AW'(r_i) * AW'(NUM_PBITS) + AW'(w_j);
    assign z           = r_z;
    assign pbit_en     = (r_state == ST_FIRE) ? (NUM_PBITS'(1) << r_i) : '0;
    assign busy        = (r_state != ST_IDLE);
    assign sweep_done  = w_sweep_done;
    assign sweep_count = r_sweep_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
module tb_pbit_sweep_scheduler;

  localparam int NP     = 3;
  localparam int EN_CYC = 2;
  localparam int AW     = 4;
  localparam int NW     = 7;
  localparam int LAT    = NP + 2 + EN_CYC;
  localparam int TBL_SZ = NP * NP + NP;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic            start = 1'b0;
  logic            stop  = 1'b0;
  logic [15:0]     num_sweeps = '0;
  logic [NP-1:0]   m = '0;
  logic            tbl_rd;
  logic [AW-1:0]   tbl_addr;
  logic [NW-1:0]   tbl_data = '0;
  logic [NW-1:0]   z;
  logic [NP-1:0]   pbit_en;
  logic            busy;
  logic            sweep_done;
  logic [15:0]     sweep_count;
  logic [2:0]      dbg_state;

  pbit_sweep_scheduler #(
    .NUM_PBITS (NP),
    .EN_CYCLES (EN_CYC),
    .AW        (AW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .stop        (stop),
    .num_sweeps  (num_sweeps),
    .m           (m),
    .tbl_rd      (tbl_rd),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .z           (z),
    .pbit_en     (pbit_en),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .sweep_count (sweep_count),
    .dbg_state   (dbg_state)
  );

  // synchronous weight/bias table, one-cycle read latency
  logic [NW-1:0] tbl [0:TBL_SZ-1];
  always @(posedge CLK) if (tbl_rd) tbl_data <= tbl[tbl_addr];

  int cyc = 0;
  int t0  = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int smv(input logic [NW-1:0] x);
    int mag;
    mag = int'(x[NW-2:0]);
    return x[NW-1] ? -mag : mag;
  endfunction

  function automatic logic [NW-1:0] model_z(input int i, input logic [NP-1:0] mm);
    int s;
    s = smv(tbl[NP * NP + i]);
    for (int j = 0; j < NP; j++) begin
      if (j != i) s += mm[j] ? smv(tbl[i * NP + j]) : -smv(tbl[i * NP + j]);
    end
    if (s > 31) s = 31;
    if (s < -32) s = -32;
    if (s < 0) return NW'(64 - s);
    return NW'(s);
  endfunction

  // ---------------- scoreboard ----------------
  logic [NW-1:0] exp_z_q[$];
  logic [NP-1:0] exp_en_q[$];
  int            exp_fire_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_done_q[$];
  int            done_seen = 0;

  task automatic push_run(input int n_fires);
    for (int k = 0; k < n_fires; k++) begin
      int i;
      i = k % NP;
      exp_z_q.push_back(model_z(i, m));
      exp_en_q.push_back(NP'(1) << i);
      exp_fire_q.push_back(k * LAT + NP + 3);
      exp_addr_q.push_back(AW'(NP * NP + i));
      for (int j = 0; j < NP; j++) begin
        if (j != i) exp_addr_q.push_back(AW'(i * NP + j));
      end
      if (i == NP - 1) exp_done_q.push_back(k * LAT + LAT);
    end
  endtask

  logic [NP-1:0] prev_en = '0;
  int            en_len  = 0;
  int            rel;

  always @(negedge CLK) begin
    if (RST) begin
      prev_en = '0;
      en_len  = 0;
    end else begin
      rel = cyc - t0 + 1;
      if (tbl_rd) begin
        if (exp_addr_q.size() == 0) check("unexpected_tbl_rd", int'(tbl_addr), -1);
        else check("tbl_addr", int'(tbl_addr), int'(exp_addr_q.pop_front()));
      end
      check("en_onehot0", int'($onehot0(pbit_en)), 1);
      if (pbit_en != '0 && prev_en == '0) begin
        if (exp_z_q.size() == 0) begin
          check("unexpected_fire", int'(pbit_en), 0);
        end else begin
          check("fire_z", int'(z), int'(exp_z_q.pop_front()));
          check("fire_en", int'(pbit_en), int'(exp_en_q.pop_front()));
          check("fire_cycle", rel, exp_fire_q.pop_front());
        end
      end
      if (pbit_en != '0) en_len++;
      if (pbit_en == '0 && prev_en != '0) begin
        check("en_len", en_len, EN_CYC);
        en_len = 0;
      end
      if (sweep_done) begin
        done_seen++;
        if (exp_done_q.size() == 0) check("unexpected_done", rel, 0);
        else check("done_cycle", rel, exp_done_q.pop_front());
      end
      prev_en = pbit_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_row(input int i, input logic [NW-1:0] wa, input logic [NW-1:0] wb,
                         input logic [NW-1:0] b);
    int c;
    c = 0;
    for (int j = 0; j < NP; j++) begin
      if (j != i) begin
        tbl[i * NP + j] = (c == 0) ? wa : wb;
        c++;
      end else begin
        tbl[i * NP + j] = NW'($urandom_range(0, 127));
      end
    end
    tbl[NP * NP + i] = b;
  endtask

  task automatic do_start(input logic with_stop);
    @(negedge CLK);
    start = 1'b1;
    stop  = with_stop;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_idle(input int idle_rel);
    int waited;
    waited = 0;
    while (busy && waited < 2000) begin
      @(negedge CLK);
      waited++;
    end
    if (busy) check("idle_timeout", 1, 0);
    else check("idle_cycle", cyc - t0 + 1, idle_rel);
  endtask

  task automatic end_checks(input int exp_count, input int exp_done);
    check("sb_empty", exp_z_q.size() + exp_addr_q.size() + exp_done_q.size(), 0);
    check("sweep_count", int'(sweep_count), exp_count);
    check("done_total", done_seen, exp_done);
    check("idle_en", int'(pbit_en), 0);
  endtask

  task automatic run_sweeps(input int nsw, input logic [NP-1:0] mm);
    m          = mm;
    num_sweeps = 16'(nsw);
    done_seen  = 0;
    push_run(nsw * NP);
    do_start(1'b0);
    wait_idle(nsw * NP * LAT + 1);
    end_checks(nsw, nsw);
  endtask

  task automatic fill_random();
    for (int a = 0; a < TBL_SZ; a++) tbl[a] = NW'($urandom_range(0, 127));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < TBL_SZ; a++) tbl[a] = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", int'(busy), 0);
    check("rst_en", int'(pbit_en), 0);
    check("rst_z", int'(z), 0);
    check("rst_tbl_rd", int'(tbl_rd), 0);
    check("rst_done", int'(sweep_done), 0);
    check("rst_count", int'(sweep_count), 0);
    RST = 1'b0;
    @(negedge CLK);

    // basic field: -1, +2, bias +1
    fill_random();
    set_row(0, 7'h44, 7'h08, 7'h04);
    run_sweeps(1, 3'b000);
    run_sweeps(1, 3'b110);

    // saturation both ways
    set_row(0, 7'h1F, 7'h1F, 7'h1F);
    run_sweeps(1, 3'b110);
    set_row(0, 7'h1F, 7'h1F, 7'h5F);
    run_sweeps(1, 3'b000);

    // negative-zero bias with zero weights
    for (int i = 0; i < NP; i++) set_row(i, 7'h00, 7'h00, 7'h40);
    run_sweeps(1, NP'($urandom_range(0, 7)));

    // random tables, two sweeps, sequencing and sweep_done timing
    for (int r = 0; r < 2; r++) begin
      fill_random();
      run_sweeps(2, NP'($urandom_range(0, 7)));
    end

    // free-run, stop during FETCH of p-bit 1
    fill_random();
    m          = 3'b101;
    num_sweeps = 16'd0;
    done_seen  = 0;
    push_run(2);
    do_start(1'b0);
    repeat (7) @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    wait_idle(2 * LAT + 1);
    end_checks(0, 0);

    // start and stop in the same idle cycle
    num_sweeps = 16'd5;
    done_seen  = 0;
    push_run(1);
    do_start(1'b1);
    wait_idle(LAT + 1);
    end_checks(0, 0);

    // start while busy is ignored
    fill_random();
    m          = 3'b011;
    num_sweeps = 16'd1;
    done_seen  = 0;
    push_run(NP);
    do_start(1'b0);
    repeat (9) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle(NP * LAT + 1);
    end_checks(1, 1);

    // asynchronous reset in the middle of FIRE
    set_row(0, 7'h44, 7'h08, 7'h04);
    m          = 3'b110;
    num_sweeps = 16'd1;
    done_seen  = 0;
    push_run(1);
    for (int i = 1; i < NP; i++) void'(exp_done_q.size());
    do_start(1'b0);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("async_rst_en", int'(pbit_en), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_z", int'(z), 0);
    check("async_rst_done", int'(sweep_done), 0);
    exp_addr_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("sb_empty_rst", exp_z_q.size() + exp_done_q.size(), 0);
    @(negedge CLK);
    run_sweeps(1, 3'b110);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
